// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch unit.
//   fetch_state_t : fetch FSM state encoding (FETCH, HALTED)
//   PC_STEP       : byte increment between sequential instruction words
//   HALT_WORD     : instruction word that stops fetch (FETCH_HALT_EN builds only)
//   RESET_PC      : program counter value after reset
// Constants are 64 bits wide (the widest supported WIDTH); users cast them to WIDTH.
package fetch_pkg;

  typedef enum logic [0:0] {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  localparam int unsigned PC_STEP   = 4;
  localparam logic [63:0] HALT_WORD = '0;
  localparam logic [63:0] RESET_PC  = '0;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: bus between the fetch unit, instruction memory, execute and decode.
//   imem_addr     fetch -> imem     word-aligned byte address (equals pc)
//   imem_rd       imem  -> fetch    instruction word, combinational from imem_addr
//   branch_taken  exec  -> fetch    single-cycle redirect pulse
//   branch_target exec  -> fetch    redirect byte address (bits [1:0] ignored)
//   dec_ready     dec   -> fetch    decode accepts instr this cycle
//   instr         fetch -> dec      fetched instruction word
//   instr_pc      fetch -> dec      byte address instr was fetched from
//   instr_valid   fetch -> dec      instr/instr_pc valid
//   halted        fetch -> anyone   fetch stopped on halt word
//
// Handshake: a word transfers to decode on a rising edge where instr_valid=1
// and dec_ready=1. While instr_valid=1 and dec_ready=0, instr and instr_pc
// are held stable. instr_valid never depends combinationally on dec_ready.
// A branch_taken pulse flushes the held word regardless of dec_ready.
interface fetch_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] imem_addr;
  logic [WIDTH-1:0] imem_rd;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             dec_ready;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] instr_pc;
  logic             instr_valid;
  logic             halted;

  // Fetch unit side.
  modport master (
    output imem_addr,
    input  imem_rd,
    input  branch_taken,
    input  branch_target,
    input  dec_ready,
    output instr,
    output instr_pc,
    output instr_valid,
    output halted
  );

  // Environment side (memory, execute, decode).
  modport slave (
    input  imem_addr,
    output imem_rd,
    output branch_taken,
    output branch_target,
    output dec_ready,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    input  halted
  );
endinterface

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter register.
//   clk, reset : clock, synchronous active-high reset (pc <= RESET_PC)
//   advance    : pc <= pc + PC_STEP (wraps modulo 2^WIDTH)
//   redirect   : pc <= target with bits [1:0] cleared; wins over advance
//   target     : redirect byte address
//   pc         : current program counter
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic             redirect,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
  localparam logic [WIDTH-1:0] STEP       = WIDTH'(PC_STEP);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= WIDTH'(RESET_PC);
    end else if (redirect) begin
      pc <= target & ALIGN_MASK;
    end else if (advance) begin
      pc <= pc + STEP;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: initiator side of the instruction-memory read port.
// Drives imem_addr from the pc, registers the returned word together with its
// pc into a one-entry fetch register, and hands it to decode via a
// valid/ready handshake. Execute can redirect the pc with branch_taken.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_if.master (memory, branch, decode signals)
//   state_dbg  : current FSM state (0 = FETCH, 1 = HALTED)
// Build option: FETCH_HALT_EN enables stopping fetch on an all-zero word.
// Priority: reset > branch_taken > halt detection > stall > normal load.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  fetch_if.master     bus,
  output logic [0:0]  state_dbg
);

  localparam logic [0:0] ST_FETCH  = FETCH;
  localparam logic [0:0] ST_HALTED = HALTED;

  logic [0:0]       state;
  logic [WIDTH-1:0] pc;
  logic             load_ok;
  logic             halt_hit;
  logic             advance;

  // Fetch register may be refilled when empty or being consumed this cycle;
  // a redirect suppresses the load so the flushed slot stays empty.
  assign load_ok = (state == ST_FETCH) && !bus.branch_taken &&
                   (!bus.instr_valid || bus.dec_ready);

`ifdef FETCH_HALT_EN
  assign halt_hit = load_ok && (bus.imem_rd == WIDTH'(HALT_WORD));
`else
  assign halt_hit = 1'b0;
`endif

  // pc only moves past words that were actually delivered; on a halt word it
  // stays pointing at that word.
  assign advance = load_ok && !halt_hit;

  fetch_pc_reg #(
    .WIDTH (WIDTH)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .advance  (advance),
    .redirect (bus.branch_taken),
    .target   (bus.branch_target),
    .pc       (pc)
  );

  assign bus.imem_addr = pc;
  assign state_dbg     = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_FETCH;
      bus.instr       <= '0;
      bus.instr_pc    <= '0;
      bus.instr_valid <= 1'b0;
    end else if (bus.branch_taken) begin
      // Flush even if decode is consuming the word this cycle.
      state           <= ST_FETCH;
      bus.instr_valid <= 1'b0;
    end else if (halt_hit) begin
      state           <= ST_HALTED;
      bus.instr_valid <= 1'b0;
    end else if (advance) begin
      bus.instr       <= bus.imem_rd;
      bus.instr_pc    <= pc;
      bus.instr_valid <= 1'b1;
    end
    // Otherwise stall (or sit in HALTED with instr_valid already 0): hold.
  end

`ifdef FETCH_HALT_EN
  assign bus.halted = (state == ST_HALTED);
`else
  assign bus.halted = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: table-driven cycle vectors plus a
// hand-written halt-word sequence (expectations depend on FETCH_HALT_EN).
module tb_instruction_fetch_unit;

  localparam int W = 64;

  logic       clk;
  logic       reset;
  logic [0:0] state_dbg;
  int         pass_cnt;
  int         total_cnt;

  fetch_if #(.WIDTH(W)) bus ();

  instruction_fetch_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  // Distinct non-zero word per address, except address 0x34 holds the halt word.
  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    if (a == 64'h34) return '0;
    return {a[31:0] ^ 32'hDEAD_BEEF, ~a[31:0]};
  endfunction

  assign bus.imem_rd = mem_word(bus.imem_addr);

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock: drive inputs after the falling edge, sample #1 after rising edge.
  task automatic step(input logic rst, input logic dr, input logic bt, input logic [W-1:0] tgt);
    @(negedge clk);
    reset             = rst;
    bus.dec_ready     = dr;
    bus.branch_taken  = bt;
    bus.branch_target = tgt;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         rst;
    logic         dr;
    logic         bt;
    logic [W-1:0] tgt;
    logic         exp_valid;
    logic [W-1:0] exp_pc;
    logic [W-1:0] exp_addr;
  } vec_t;

  vec_t vecs[21];

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    reset = 1'b1;
    bus.dec_ready = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = '0;

    //            rst   dr    bt    tgt                     valid pc                      addr
    // sequential fetch and stall
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 64'h0,                  1'b0, 64'h0,                  64'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 64'h0,                  1'b1, 64'h0,                  64'h4};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 64'h0,                  1'b1, 64'h4,                  64'h8};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 64'h0,                  1'b1, 64'h8,                  64'hC};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 64'h0,                  1'b1, 64'h8,                  64'hC};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 64'h0,                  1'b1, 64'h8,                  64'hC};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 64'h0,                  1'b1, 64'h8,                  64'hC};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 64'h0,                  1'b1, 64'hC,                  64'h10};
    // branch while instr_pc=4 is valid and being consumed
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 64'h0,                  1'b0, 64'h0,                  64'h0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 64'h0,                  1'b1, 64'h0,                  64'h4};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 64'h0,                  1'b1, 64'h4,                  64'h8};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 64'h53,                 1'b0, 64'h4,                  64'h50};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 64'h0,                  1'b1, 64'h50,                 64'h54};
    // branch during a stall, then refill into the empty slot with dec_ready=0
    vecs[13] = '{1'b0, 1'b0, 1'b1, 64'h100,                1'b0, 64'h50,                 64'h100};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 64'h0,                  1'b1, 64'h100,                64'h104};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 64'h0,                  1'b1, 64'h100,                64'h104};
    // reset while stalled with a valid word
    vecs[16] = '{1'b1, 1'b0, 1'b0, 64'h0,                  1'b0, 64'h0,                  64'h0};
    // pc wrap at the top of the address space
    vecs[17] = '{1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0,                 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 64'h0,                  1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 64'h0,                  1'b1, 64'h0,                  64'h4};
    // reset wins over a simultaneous branch
    vecs[20] = '{1'b1, 1'b1, 1'b1, 64'h80,                 1'b0, 64'h0,                  64'h0};

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].rst, vecs[i].dr, vecs[i].bt, vecs[i].tgt);
      check($sformatf("v%0d valid", i), W'(bus.instr_valid), W'(vecs[i].exp_valid));
      check($sformatf("v%0d imem_addr", i), bus.imem_addr, vecs[i].exp_addr);
      check($sformatf("v%0d halted", i), W'(bus.halted), '0);
      if (vecs[i].rst) begin
        check($sformatf("v%0d rst instr", i), bus.instr, '0);
        check($sformatf("v%0d rst instr_pc", i), bus.instr_pc, '0);
        check($sformatf("v%0d rst state", i), W'(state_dbg), '0);
      end else if (vecs[i].exp_valid) begin
        check($sformatf("v%0d instr_pc", i), bus.instr_pc, vecs[i].exp_pc);
        check($sformatf("v%0d instr", i), bus.instr, mem_word(vecs[i].exp_pc));
      end
    end

    // ---------------- halt-word sequence ----------------
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 64'h2C);       // redirect to 0x2C
    check("h redirect addr", bus.imem_addr, 64'h2C);
    step(1'b0, 1'b1, 1'b0, '0);           // deliver 0x2C
    check("h pc 2c", bus.instr_pc, 64'h2C);
    step(1'b0, 1'b1, 1'b0, '0);           // deliver 0x30
    check("h pc 30", bus.instr_pc, 64'h30);
    check("h addr 34", bus.imem_addr, 64'h34);
    step(1'b0, 1'b1, 1'b0, '0);           // word at 0x34 is zero
`ifdef FETCH_HALT_EN
    check("h halted", W'(bus.halted), W'(1));
    check("h halt valid", W'(bus.instr_valid), '0);
    check("h halt addr", bus.imem_addr, 64'h34);
    check("h halt state", W'(state_dbg), W'(1));
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    check("h held halted", W'(bus.halted), W'(1));
    check("h held valid", W'(bus.instr_valid), '0);
    check("h held addr", bus.imem_addr, 64'h34);
    step(1'b0, 1'b1, 1'b1, 64'h10);       // branch leaves HALTED
    check("h resume halted", W'(bus.halted), '0);
    check("h resume valid", W'(bus.instr_valid), '0);
    check("h resume addr", bus.imem_addr, 64'h10);
    step(1'b0, 1'b1, 1'b0, '0);
    check("h resume pc", bus.instr_pc, 64'h10);
    check("h resume instr", bus.instr, mem_word(64'h10));
    check("h resume valid2", W'(bus.instr_valid), W'(1));
`else
    check("h zero valid", W'(bus.instr_valid), W'(1));
    check("h zero pc", bus.instr_pc, 64'h34);
    check("h zero instr", bus.instr, '0);
    check("h zero addr", bus.imem_addr, 64'h38);
    check("h zero halted", W'(bus.halted), '0);
    check("h zero state", W'(state_dbg), '0);
`endif

    // reset returns everything to idle after the sequence
    step(1'b1, 1'b0, 1'b0, '0);
    check("final valid", W'(bus.instr_valid), '0);
    check("final addr", bus.imem_addr, '0);
    check("final halted", W'(bus.halted), '0);

    bus.branch_taken = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
